// File: rtl/onchip_ram_pkg.sv
// Shared constants for the pipelined on-chip RAM.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default geometry
//   LAT_UNREG / LAT_REG                 : read latency without / with output register
//   idx_width()                         : storage index width for a given depth
package onchip_ram_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DEPTH_DEF  = 8192;

    localparam int unsigned LAT_UNREG = 1;
    localparam int unsigned LAT_REG   = 2;

    // A single-word memory still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled synchronous storage with a registered read port.
//   i_clk    : clock
//   i_rst_n  : async active-low reset (clears the read register only, never the array)
//   i_we     : write strobe, i_be selects the bytes written from i_wdata
//   i_addr   : word index, must already be range-checked by the caller
//   i_re     : read strobe; o_rdata loads mem[i_addr] and holds otherwise
//   INIT_FILE: name of an optional hex image for the array
module onchip_ram_core
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned IDX_W     = idx_width(DEPTH),
    parameter string       INIT_FILE = ""
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_re,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array has no reset so contents survive reset_n.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Loads only on a read so the value holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Pipelined on-chip RAM slave with stall, freeze and out-of-range handling.
//   clk, reset_n      : clock, async active-low reset
//   address           : word address (ADDR_W bits)
//   byteenable        : per-byte write enable
//   chipselect/read/write/writedata : request interface; read+write acts as write
//   clken, reset_req  : clken=0 or reset_req=1 stalls the whole block
//   freeze            : accepted writes are dropped
//   readdata          : read result, holds when readdatavalid=0
//   readdatavalid     : one pulse per accepted read, 1+OUT_REG enabled cycles later
//   waitrequest       : ~clken | reset_req
//   err_oor           : sticky, set by any accepted access at address >= DEPTH
module onchip_ram_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned OUT_REG   = 0,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    input  logic                freeze,
    input  logic                reset_req,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                err_oor
);

    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned LAT   = (OUT_REG != 0) ? LAT_REG : LAT_UNREG;

    logic              w_en;
    logic              w_accept;
    logic              w_wr;
    logic              w_rd;
    logic              w_oor;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [DATA_W-1:0] w_core_rdata;
    logic [DATA_W-1:0] w_s1_data;
    logic              w_out_vld;
    logic [DATA_W-1:0] w_out_data;

    logic              r_vld1;
    logic              r_oor1;
    logic              r_err;

    assign waitrequest = ~clken | reset_req;
    assign w_en        = ~waitrequest;
    assign w_accept    = chipselect & (read | write) & w_en;
    assign w_wr        = w_accept & write;
    assign w_rd        = w_accept & read & ~write;

    // Extra bit so DEPTH == 2**ADDR_W is representable.
    assign w_oor       = {1'b0, address} >= (ADDR_W+1)'(DEPTH);

    assign w_mem_we    = w_wr & ~freeze & ~w_oor;
    assign w_mem_re    = w_rd & ~w_oor;

    onchip_ram_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_mem_we),
        .i_be    (byteenable),
        .i_addr  (address[IDX_W-1:0]),
        .i_wdata (writedata),
        .i_re    (w_mem_re),
        .o_rdata (w_core_rdata)
    );

    // Stage 1 tracks the read sitting in the core's read register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld1 <= 1'b0;
            r_oor1 <= 1'b0;
        end else if (w_en) begin
            r_vld1 <= w_rd;
            if (w_rd) begin
                r_oor1 <= w_oor;
            end
        end
    end

    // Out-of-range reads leave the core register untouched; mask it to zero.
    assign w_s1_data = r_oor1 ? '0 : w_core_rdata;

    generate
        if (LAT == LAT_REG) begin : g_out_reg
            logic              r_vld2;
            logic [DATA_W-1:0] r_data2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld2  <= 1'b0;
                    r_data2 <= '0;
                end else if (w_en) begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_data2 <= w_s1_data;
                    end
                end
            end

            assign w_out_vld  = r_vld2;
            assign w_out_data = r_data2;
        end else begin : g_out_direct
            assign w_out_vld  = r_vld1;
            assign w_out_data = w_s1_data;
        end
    endgenerate

    // A held result is only presented on an edge that actually advances the pipe,
    // so a stalled edge never consumes it.
    assign readdatavalid = w_out_vld & w_en;
    assign readdata      = w_out_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept & w_oor) begin
            r_err <= 1'b1;
        end
    end

    assign err_oor = r_err;

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Directed bench: dut0 is OUT_REG=0 with DEPTH=4096, dut1 is OUT_REG=1 with DEPTH=8192.
// Both share the same stimulus. Inputs change 1ns after posedge; outputs are compared
// at negedge, i.e. the values the master samples on the coming edge.
module tb_onchip_ram_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic        freeze;
    logic        reset_req;

    logic [31:0] rd0, rd1;
    logic        rdv0, rdv1;
    logic        wait0, wait1;
    logic        err0, err1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    onchip_ram_pipelined #(
        .DATA_W (32), .ADDR_W (13), .DEPTH (4096), .OUT_REG (0), .INIT_FILE ("")
    ) dut0 (
        .clk (clk), .reset_n (reset_n), .address (address), .byteenable (byteenable),
        .chipselect (chipselect), .read (read), .write (write), .writedata (writedata),
        .clken (clken), .freeze (freeze), .reset_req (reset_req),
        .readdata (rd0), .readdatavalid (rdv0), .waitrequest (wait0), .err_oor (err0)
    );

    onchip_ram_pipelined #(
        .DATA_W (32), .ADDR_W (13), .DEPTH (8192), .OUT_REG (1), .INIT_FILE ("")
    ) dut1 (
        .clk (clk), .reset_n (reset_n), .address (address), .byteenable (byteenable),
        .chipselect (chipselect), .read (read), .write (write), .writedata (writedata),
        .clken (clken), .freeze (freeze), .reset_req (reset_req),
        .readdata (rd1), .readdatavalid (rdv1), .waitrequest (wait1), .err_oor (err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = 4'hF;
        writedata  = '0;
        freeze     = 1'b0;
    endtask

    task automatic do_wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = a;
        writedata  = d;
        byteenable = be;
    endtask

    task automatic do_rd(input logic [12:0] a);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = a;
    endtask

    // Single read; dut0 answers one cycle later, dut1 two cycles later.
    task automatic rd_check(input string tag, input logic [12:0] a, input logic [31:0] exp,
                            input logic cmp1);
        do_rd(a);
        nxt();
        set_idle();
        smp();
        chk({tag, "_rdv0"}, 32'(rdv0), 32'd1);
        chk({tag, "_data0"}, rd0, exp);
        chk({tag, "_rdv1_early"}, 32'(rdv1), 32'd0);
        nxt();
        smp();
        chk({tag, "_rdv0_done"}, 32'(rdv0), 32'd0);
        chk({tag, "_data0_hold"}, rd0, exp);
        chk({tag, "_rdv1"}, 32'(rdv1), 32'd1);
        if (cmp1) chk({tag, "_data1"}, rd1, exp);
        nxt();
    endtask

    initial begin
        reset_n   = 1'b0;
        clken     = 1'b1;
        reset_req = 1'b0;
        set_idle();
        #1;
        chk("rst_rdv0", 32'(rdv0), 32'd0);
        chk("rst_rdv1", 32'(rdv1), 32'd0);
        chk("rst_data0", rd0, 32'd0);
        chk("rst_data1", rd1, 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_wait0", 32'(wait0), 32'd0);
        nxt();
        nxt();
        reset_n = 1'b1;

        // Write then immediate read of the same word.
        do_wr(13'h10, 32'hDEADBEEF, 4'hF);
        nxt();
        rd_check("raw", 13'h10, 32'hDEADBEEF, 1'b1);

        // Partial byte write.
        do_wr(13'h20, 32'hFFFFFFFF, 4'hF);
        nxt();
        do_wr(13'h20, 32'h11223344, 4'b0101);
        nxt();
        rd_check("be", 13'h20, 32'hFF22FF44, 1'b1);

        // Frozen write is dropped.
        do_wr(13'h30, 32'hAAAAAAAA, 4'hF);
        nxt();
        do_wr(13'h30, 32'h12345678, 4'hF);
        freeze = 1'b1;
        nxt();
        freeze = 1'b0;
        rd_check("frz", 13'h30, 32'hAAAAAAAA, 1'b1);

        // read+write together acts as a write only.
        do_wr(13'h40, 32'h0BADF00D, 4'hF);
        read = 1'b1;
        nxt();
        set_idle();
        smp();
        chk("rw_rdv0", 32'(rdv0), 32'd0);
        nxt();
        smp();
        chk("rw_rdv1", 32'(rdv1), 32'd0);
        rd_check("rw", 13'h40, 32'h0BADF00D, 1'b1);

        // reset_req stalls like clken=0.
        do_rd(13'h10);
        nxt();
        set_idle();
        reset_req = 1'b1;
        smp();
        chk("rq_wait", 32'(wait0), 32'd1);
        chk("rq_rdv0", 32'(rdv0), 32'd0);
        nxt();
        reset_req = 1'b0;
        smp();
        chk("rq_rdv0_late", 32'(rdv0), 32'd1);
        chk("rq_data0", rd0, 32'hDEADBEEF);
        nxt();
        smp();
        chk("rq_rdv1", 32'(rdv1), 32'd1);
        chk("rq_data1", rd1, 32'hDEADBEEF);
        nxt();

        // Back-to-back reads with a two-cycle clken stall.
        for (int i = 0; i < 4; i++) begin
            do_wr(13'(i), 32'hC0DE0000 + 32'(i), 4'hF);
            nxt();
        end
        do_rd(13'h0);
        nxt();
        do_rd(13'h1);
        smp();
        chk("bb_c1_rdv1", 32'(rdv1), 32'd0);
        chk("bb_c1_rdv0", 32'(rdv0), 32'd1);
        chk("bb_c1_data0", rd0, 32'hC0DE0000);
        nxt();
        clken = 1'b0;
        do_rd(13'h2);
        smp();
        chk("bb_st1_wait", 32'(wait1), 32'd1);
        chk("bb_st1_rdv0", 32'(rdv0), 32'd0);
        chk("bb_st1_rdv1", 32'(rdv1), 32'd0);
        chk("bb_st1_data1", rd1, 32'hC0DE0000);
        nxt();
        smp();
        chk("bb_st2_rdv1", 32'(rdv1), 32'd0);
        nxt();
        clken = 1'b1;
        smp();
        chk("bb_c4_rdv1", 32'(rdv1), 32'd1);
        chk("bb_c4_data1", rd1, 32'hC0DE0000);
        chk("bb_c4_data0", rd0, 32'hC0DE0001);
        nxt();
        do_rd(13'h3);
        smp();
        chk("bb_c5_rdv1", 32'(rdv1), 32'd1);
        chk("bb_c5_data1", rd1, 32'hC0DE0001);
        chk("bb_c5_data0", rd0, 32'hC0DE0002);
        nxt();
        set_idle();
        smp();
        chk("bb_c6_rdv1", 32'(rdv1), 32'd1);
        chk("bb_c6_data1", rd1, 32'hC0DE0002);
        chk("bb_c6_data0", rd0, 32'hC0DE0003);
        nxt();
        smp();
        chk("bb_c7_data1", rd1, 32'hC0DE0003);
        chk("bb_c7_rdv0", 32'(rdv0), 32'd0);
        nxt();
        smp();
        chk("bb_c8_rdv1", 32'(rdv1), 32'd0);
        nxt();

        // Out of range on dut0 only (in range for dut1).
        chk("oor_err0_pre", 32'(err0), 32'd0);
        rd_check("oor", 13'h1000, 32'd0, 1'b0);
        chk("oor_err0", 32'(err0), 32'd1);
        chk("oor_err1", 32'(err1), 32'd0);
        do_wr(13'h1000, 32'h55555555, 4'hF);
        nxt();
        set_idle();
        rd_check("oor_alias", 13'h0, 32'hC0DE0000, 1'b1);
        chk("oor_err0_sticky", 32'(err0), 32'd1);

        // Reset with reads in flight.
        do_rd(13'h10);
        nxt();
        do_rd(13'h20);
        nxt();
        reset_n = 1'b0;
        set_idle();
        #1;
        chk("rf_rdv0", 32'(rdv0), 32'd0);
        chk("rf_rdv1", 32'(rdv1), 32'd0);
        chk("rf_data0", rd0, 32'd0);
        chk("rf_data1", rd1, 32'd0);
        chk("rf_err0", 32'(err0), 32'd0);
        nxt();
        nxt();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("rf_quiet", 32'(rdv0 | rdv1), 32'd0);
            nxt();
        end
        rd_check("rf_keep_a", 13'h10, 32'hDEADBEEF, 1'b1);
        rd_check("rf_keep_b", 13'h20, 32'hFF22FF44, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
